avalon_mm_arbiter: RTL

- Round-robin arbiter that shares one Avalon-MM slave (a register-file CSR port) among NUM_MASTERS Avalon-MM masters.
- Sits between the bus masters (host bridge, test sequencers, DMA-style engines) and the avalon_mm_if slave port of a register block.
- Grants one whole transaction at a time: a write, or a read plus its readdatavalid return.
- Allows at most one outstanding read.

---
 rtl/avalon_mm_arb_pkg.sv | 17 +
 rtl/avalon_mm_arbiter_rr.sv | 26 ++
 rtl/avalon_mm_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/avalon_mm_arb_pkg.sv
// Shared types and constants for the Avalon-MM round-robin arbiter.
package avalon_mm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_WAIT_RD = 2'd2
  } arb_state_t;

  // Returned as read data when a read return never arrives.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic int calc_awidth(input int num_regs);
    return $clog2(num_regs) + 1;
  endfunction

endpackage

// File: rtl/avalon_mm_arbiter_rr.sv
// Combinational round-robin picker: first requester above i_last_grant, wrapping.
module rr_arbiter #(
  parameter  int NUM_MASTERS = 2,
  localparam int IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IW-1:0]          i_last_grant,
  output logic                   o_valid,
  output logic [IW-1:0]          o_grant_idx
);

  always_comb begin : p_scan
    logic [IW-1:0] w_cand;
    w_cand      = '0;
    o_valid     = 1'b0;
    o_grant_idx = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      w_cand = IW'((int'(i_last_grant) + off) % NUM_MASTERS);
      if (!o_valid && i_req[w_cand]) begin
        o_valid     = 1'b1;
        o_grant_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM CSR slave among NUM_MASTERS masters.
// Optional read-return timeout enabled by defining AVALON_MM_ARB_TIMEOUT_EN.
//
// state      | meaning
// ST_IDLE    | no grant held; arbitrate among requesters
// ST_BUSY    | granted master's strobes muxed to the slave until accepted or dropped
// ST_WAIT_RD | read accepted; waiting for the slave's readdatavalid
module avalon_mm_arbiter
  import avalon_mm_arb_pkg::*;
#(
  parameter  int DWIDTH         = 32,
  parameter  int NUM_REGS       = 4,
  parameter  int NUM_MASTERS    = 2,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int AWIDTH         = calc_awidth(NUM_REGS),
  localparam int IW             = $clog2(NUM_MASTERS)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_MASTERS*AWIDTH-1:0] m_address_i,
  input  logic [NUM_MASTERS-1:0]        m_write_i,
  input  logic [NUM_MASTERS*DWIDTH-1:0] m_writedata_i,
  input  logic [NUM_MASTERS-1:0]        m_read_i,
  output logic [NUM_MASTERS-1:0]        m_waitrequest_o,
  output logic [DWIDTH-1:0]             m_readdata_o,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid_o,
  output logic [AWIDTH-1:0]             s_address_o,
  output logic                          s_write_o,
  output logic [DWIDTH-1:0]             s_writedata_o,
  output logic                          s_read_o,
  input  logic                          s_waitrequest_i,
  input  logic [DWIDTH-1:0]             s_readdata_i,
  input  logic                          s_readdatavalid_i
`ifdef AVALON_MM_ARB_TIMEOUT_EN
  ,
  output logic                          timeout_o
`endif
);

  if (NUM_MASTERS < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("avalon_mm_arbiter: NUM_MASTERS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [IW-1:0]         r_grant;
  logic [IW-1:0]         r_last_grant;
  logic [IW-1:0]         w_arb_idx;
  logic                  w_arb_valid;
  logic [NUM_MASTERS-1:0] w_req;
  logic                  w_g_write;
  logic                  w_g_read;
  logic                  w_timeout;

  assign w_req     = m_read_i | m_write_i;
  // Write wins if a master ever raises both strobes.
  assign w_g_write = m_write_i[r_grant];
  assign w_g_read  = m_read_i[r_grant] & ~w_g_write;

  rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_valid      (w_arb_valid),
    .o_grant_idx  (w_arb_idx)
  );

`ifdef AVALON_MM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                  r_to_cnt <= '0;
    else if (r_state != ST_WAIT_RD) r_to_cnt <= '0;
    else                           r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout    = (r_state == ST_WAIT_RD) && !s_readdatavalid_i &&
                        (r_to_cnt == CW'(TIMEOUT_CYCLES));
  assign timeout_o    = w_timeout;
  assign m_readdata_o = w_timeout ? DWIDTH'(TIMEOUT_DATA) : s_readdata_i;
`else
  assign w_timeout    = 1'b0;
  assign m_readdata_o = s_readdata_i;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    s_write_o         = 1'b0;
    s_read_o          = 1'b0;
    s_address_o       = '0;
    s_writedata_o     = '0;
    m_waitrequest_o   = '1;
    m_readdatavalid_o = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        s_write_o                = w_g_write;
        s_read_o                 = w_g_read;
        s_address_o              = m_address_i[int'(r_grant)*AWIDTH +: AWIDTH];
        s_writedata_o            = m_writedata_i[int'(r_grant)*DWIDTH +: DWIDTH];
        m_waitrequest_o[r_grant] = s_waitrequest_i;
        if (w_g_write && !s_waitrequest_i)     w_state_nxt = ST_IDLE;
        else if (w_g_read && !s_waitrequest_i) w_state_nxt = ST_WAIT_RD;
        else if (!w_g_write && !w_g_read)      w_state_nxt = ST_IDLE;
      end
      ST_WAIT_RD: begin
        if (s_readdatavalid_i || w_timeout) begin
          m_readdatavalid_o[r_grant] = 1'b1;
          w_state_nxt                = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IW'(NUM_MASTERS - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_arb_valid) begin
        r_grant      <= w_arb_idx;
        r_last_grant <= w_arb_idx;
      end
    end
  end

endmodule
